// File: rtl/dvi_tmds_encoder_if.sv
// Pixel-side bundle between the video controller and the TMDS encoder, plus the three
// encoded channel symbols handed on to the serialiser.
interface dvi_tmds_encoder_if;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic [23:0] rgb;
  logic [9:0]  tmds_r;
  logic [9:0]  tmds_g;
  logic [9:0]  tmds_b;

  modport master (
    output hsync, vsync, blank, rgb,
    input  tmds_r, tmds_g, tmds_b
  );

  modport slave (
    input  hsync, vsync, blank, rgb,
    output tmds_r, tmds_g, tmds_b
  );
endinterface

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b encoder for R, G and B. Stage 1 builds the transition-minimised
// word q_m, stage 2 applies DC balancing or control codes; two-register pipeline.
module dvi_tmds_encoder #(
  parameter bit INVERT_SYNC = 1'b0
) (
  input logic              clk_pixel,
  input logic              reset,
  dvi_tmds_encoder_if.slave vid
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, d[i]};
    end
    return n;
  endfunction

  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm;
    n1d      = popcount8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && (d[0] == 1'b0));
    qm       = 9'd0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor;
    return qm;
  endfunction

  function automatic logic [9:0] tmds_ctrl(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'b00:   sym = CTRL_00;
      2'b01:   sym = CTRL_01;
      2'b10:   sym = CTRL_10;
      2'b11:   sym = CTRL_11;
      default: sym = CTRL_00;
    endcase
    return sym;
  endfunction

  // cnt is the running (ones - zeros) of the emitted symbols; result is {symbol, next cnt}
  function automatic logic [14:0] tmds_data(input logic [8:0] qm, input logic signed [4:0] cnt);
    logic signed [4:0] n1;
    logic signed [4:0] n0;
    logic signed [4:0] cnt_n;
    logic [9:0]        sym;
    n1 = $signed({1'b0, popcount8(qm[7:0])});
    n0 = 5'sd8 - n1;
    if ((cnt == 5'sd0) || (n1 == n0)) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt + n1 - n0) : (cnt + n0 - n1);
    end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 5'sd2 : 5'sd0) + n0 - n1;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt + n1 - n0 - (qm[8] ? 5'sd0 : 5'sd2);
    end
    return {sym, cnt_n};
  endfunction

  logic [8:0]        qm_red_q, qm_grn_q, qm_blu_q;
  logic [8:0]        qm_red_d, qm_grn_d, qm_blu_d;
  logic              blank_q, c0_q, c1_q;
  logic              blank_d, c0_d, c1_d;
  logic [9:0]        tmds_red_q, tmds_grn_q, tmds_blu_q;
  logic [9:0]        tmds_red_d, tmds_grn_d, tmds_blu_d;
  logic signed [4:0] cnt_red_q, cnt_grn_q, cnt_blu_q;
  logic signed [4:0] cnt_red_d, cnt_grn_d, cnt_blu_d;

  // Stage 1 next state; pixel data is forced to zero while blanked so X never enters q_m
  always_comb begin
    qm_red_d = tmds_qm(vid.blank ? 8'd0 : vid.rgb[23:16]);
    qm_grn_d = tmds_qm(vid.blank ? 8'd0 : vid.rgb[15:8]);
    qm_blu_d = tmds_qm(vid.blank ? 8'd0 : vid.rgb[7:0]);
    blank_d  = vid.blank;
    c0_d     = vid.hsync ^ INVERT_SYNC;
    c1_d     = vid.vsync ^ INVERT_SYNC;
  end

  // Stage 1 registers
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      qm_red_q <= 9'd0;
      qm_grn_q <= 9'd0;
      qm_blu_q <= 9'd0;
      blank_q  <= 1'b1;
      c0_q     <= 1'b0;
      c1_q     <= 1'b0;
    end else begin
      qm_red_q <= qm_red_d;
      qm_grn_q <= qm_grn_d;
      qm_blu_q <= qm_blu_d;
      blank_q  <= blank_d;
      c0_q     <= c0_d;
      c1_q     <= c1_d;
    end
  end

  // Stage 2 next state: control codes clear disparity, data symbols carry it forward
  always_comb begin
    if (blank_q) begin
      tmds_red_d = CTRL_00;
      tmds_grn_d = CTRL_00;
      tmds_blu_d = tmds_ctrl({c1_q, c0_q});
      cnt_red_d  = 5'sd0;
      cnt_grn_d  = 5'sd0;
      cnt_blu_d  = 5'sd0;
    end else begin
      {tmds_red_d, cnt_red_d} = tmds_data(qm_red_q, cnt_red_q);
      {tmds_grn_d, cnt_grn_d} = tmds_data(qm_grn_q, cnt_grn_q);
      {tmds_blu_d, cnt_blu_d} = tmds_data(qm_blu_q, cnt_blu_q);
    end
  end

  // Stage 2 registers drive the symbol outputs directly
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tmds_red_q <= CTRL_00;
      tmds_grn_q <= CTRL_00;
      tmds_blu_q <= CTRL_00;
      cnt_red_q  <= 5'sd0;
      cnt_grn_q  <= 5'sd0;
      cnt_blu_q  <= 5'sd0;
    end else begin
      tmds_red_q <= tmds_red_d;
      tmds_grn_q <= tmds_grn_d;
      tmds_blu_q <= tmds_blu_d;
      cnt_red_q  <= cnt_red_d;
      cnt_grn_q  <= cnt_grn_d;
      cnt_blu_q  <= cnt_blu_d;
    end
  end

  assign vid.tmds_r = tmds_red_q;
  assign vid.tmds_g = tmds_grn_q;
  assign vid.tmds_b = tmds_blu_q;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed and decode-based checks for dvi_tmds_encoder: reset, control codes, disparity
// sequences across blank edges, mid-line reset and a random round-trip through a decoder.
module tb_dvi_tmds_encoder;

  logic clk_pixel;
  logic reset;
  int   checks;
  int   errors;

  dvi_tmds_encoder_if vid_if ();

  dvi_tmds_encoder #(.INVERT_SYNC(1'b0)) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .vid       (vid_if)
  );

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic drive(input logic b, input logic hs, input logic vs, input logic [23:0] d);
    vid_if.blank = b;
    vid_if.hsync = hs;
    vid_if.vsync = vs;
    vid_if.rgb   = d;
  endtask

  function automatic logic [9:0] sym(input int c);
    case (c)
      0:       return vid_if.tmds_r;
      1:       return vid_if.tmds_g;
      default: return vid_if.tmds_b;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 24'($urandom()));
      tick();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (sym(c) !== 10'h354) begin
          errors++;
          $display("FAIL reset_hold cyc%0d ch%0d: got %h expected %h", i, c, sym(c), 10'h354);
        end
      end
    end
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (sym(c) !== 10'h354) begin
          errors++;
          $display("FAIL reset_release cyc%0d ch%0d: got %h expected %h", i, c, sym(c), 10'h354);
        end
      end
    end
  endtask

  task automatic test_control();
    logic [9:0] exp_b [4];
    logic [1:0] vh    [4];
    exp_b = '{10'h0AB, 10'h2AB, 10'h154, 10'h354};
    vh    = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, vh[k][0], vh[k][1], 24'hxxxxxx);
      tick();
      tick();
      checks++;
      if (vid_if.tmds_b !== exp_b[k]) begin
        errors++;
        $display("FAIL control_b vs,hs=%b: got %h expected %h", vh[k], vid_if.tmds_b, exp_b[k]);
      end
      checks++;
      if (vid_if.tmds_r !== 10'h354 || vid_if.tmds_g !== 10'h354) begin
        errors++;
        $display("FAIL control_rg vs,hs=%b: got r=%h g=%h expected %h", vh[k],
                 vid_if.tmds_r, vid_if.tmds_g, 10'h354);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
  endtask

  // rgb=0 held for three sampled cycles after a blank period: 0x100, 0x3FF, 0x100
  task automatic test_data_zero(input string tag);
    logic [9:0] exp_s [3];
    exp_s = '{10'h100, 10'h3FF, 10'h100};
    drive(1'b0, 1'b0, 1'b0, 24'h000000);
    tick();
    for (int s = 0; s < 3; s++) begin
      if (s == 2) drive(1'b1, 1'b0, 1'b0, 24'h000000);
      tick();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (sym(c) !== exp_s[s]) begin
          errors++;
          $display("FAIL %s sym%0d ch%0d: got %h expected %h", tag, s, c, sym(c), exp_s[s]);
        end
      end
    end
    tick();
    checks++;
    if (vid_if.tmds_b !== 10'h354) begin
      errors++;
      $display("FAIL %s trailing_ctrl: got %h expected %h", tag, vid_if.tmds_b, 10'h354);
    end
  endtask

  task automatic test_blank_transition();
    logic [9:0] exp_s [4];
    exp_s = '{10'h200, 10'h3FF, 10'h354, 10'h100};
    drive(1'b0, 1'b0, 1'b0, 24'hFFFFFF);
    tick();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       drive(1'b0, 1'b0, 1'b0, 24'h000000);
        1:       drive(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
        2:       drive(1'b0, 1'b0, 1'b0, 24'h000000);
        default: drive(1'b1, 1'b0, 1'b0, 24'h000000);
      endcase
      tick();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (sym(c) !== exp_s[s]) begin
          errors++;
          $display("FAIL blank_transition sym%0d ch%0d: got %h expected %h", s, c, sym(c), exp_s[s]);
        end
      end
    end
    tick();
  endtask

  // Per-channel vectors covering the XOR/XNOR tie-break and the case-c disparity path
  task automatic test_mixed();
    logic [23:0] vec [3];
    logic [9:0]  exp_s [3][3];
    vec   = '{24'hFFAA55, 24'hFF0000, 24'hFF0000};
    exp_s = '{'{10'h200, 10'h233, 10'h133},
              '{10'h0FF, 10'h100, 10'h100},
              '{10'h0FF, 10'h3FF, 10'h3FF}};
    drive(1'b0, 1'b0, 1'b0, vec[0]);
    tick();
    for (int s = 0; s < 3; s++) begin
      if (s < 2) drive(1'b0, 1'b0, 1'b0, vec[s+1]);
      else       drive(1'b1, 1'b0, 1'b0, 24'h000000);
      tick();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (sym(c) !== exp_s[s][c]) begin
          errors++;
          $display("FAIL mixed sym%0d ch%0d: got %h expected %h", s, c, sym(c), exp_s[s][c]);
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b0, 24'h000000);
    tick();
    tick();
    checks++;
    if (vid_if.tmds_g !== 10'h100) begin
      errors++;
      $display("FAIL reset_mid_pre: got %h expected %h", vid_if.tmds_g, 10'h100);
    end
    reset = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (sym(c) !== 10'h354) begin
        errors++;
        $display("FAIL reset_mid_ctrl ch%0d: got %h expected %h", c, sym(c), 10'h354);
      end
    end
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    tick();
    test_data_zero("reset_mid_resume");
  endtask

  // Random stream decoded back to pixels/syncs; running symbol disparity must stay bounded
  task automatic test_random();
    logic        p_blank, p_hs, p_vs;
    logic [23:0] p_rgb;
    logic        nb, nhs, nvs;
    logic [23:0] nrgb;
    logic [9:0]  s, exp_c;
    logic [7:0]  dd, dec;
    logic [9:0]  ctrl_tab [4];
    int          rd [3];
    ctrl_tab = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    rd       = '{0, 0, 0};
    p_blank = 1'b1; p_hs = 1'b0; p_vs = 1'b0; p_rgb = 24'h0;
    for (int i = 0; i < 400; i++) begin
      nb   = (i == 0) ? 1'b1 : ($urandom_range(7) == 0);
      nhs  = 1'($urandom_range(1));
      nvs  = 1'($urandom_range(1));
      nrgb = 24'($urandom());
      drive(nb, nhs, nvs, nrgb);
      tick();
      if (i > 0) begin
        for (int c = 0; c < 3; c++) begin
          s = sym(c);
          checks++;
          if (p_blank) begin
            exp_c = (c == 2) ? ctrl_tab[{p_vs, p_hs}] : 10'h354;
            rd[c] = 0;
            if (s !== exp_c) begin
              errors++;
              $display("FAIL random_ctrl cyc%0d ch%0d: got %h expected %h", i, c, s, exp_c);
            end
          end else begin
            dd     = s[9] ? ~s[7:0] : s[7:0];
            dec    = 8'd0;
            dec[0] = dd[0];
            for (int k = 1; k < 8; k++) begin
              dec[k] = s[8] ? (dd[k] ^ dd[k-1]) : ~(dd[k] ^ dd[k-1]);
            end
            rd[c] = rd[c] + 2 * $countones(s) - 10;
            if (dec !== p_rgb[8*(2-c) +: 8]) begin
              errors++;
              $display("FAIL random_decode cyc%0d ch%0d: got %h expected %h (sym %h)",
                       i, c, dec, p_rgb[8*(2-c) +: 8], s);
            end
            checks++;
            if (rd[c] > 10 || rd[c] < -10) begin
              errors++;
              $display("FAIL random_disparity cyc%0d ch%0d: got %0d expected within +/-10", i, c, rd[c]);
            end
          end
        end
      end
      p_blank = nb; p_hs = nhs; p_vs = nvs; p_rgb = nrgb;
    end
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    test_reset();
    test_control();
    test_data_zero("data_zero");
    test_blank_transition();
    test_mixed();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
